// File: rtl/acondicionador_botones.sv
// ---------------------------------------------------------------------------
// acondicionador_botones
//   Conditions the five raw drum-pad buttons before they reach the scoring
//   block. Each pad is synchronized, debounced, and turned into a single-cycle
//   hit pulse. The block also keeps a sticky pending-hit flag per pad, counts
//   the hits in each cycle, and drives a stretched LED for each pad.
//
// Ports
//   i_clk          game clock
//   i_reset        asynchronous, active-high reset
//   i_enable       game running; when 0, no hit pulses and no new pending sets
//   i_botones[4:0] raw pads, active-high (bit4 = boton1 ... bit0 = boton5)
//   i_ack[4:0]     per-bit clear of o_pendientes, driven by scoring
//   o_estable      debounced pad level
//   o_golpe        one-cycle pulse on each accepted press (0 -> 1)
//   o_pendientes   sticky hit flags
//   o_num_golpes   number of bits set in o_golpe, in the same cycle
//   o_leds         stretched hit indicator, LED_CYCLES long
// ---------------------------------------------------------------------------
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int LED_CYCLES      = 2500000,
  parameter int LED_W           = 22
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [4:0] i_botones,
  input  logic [4:0] i_ack,
  output logic [4:0] o_estable,
  output logic [4:0] o_golpe,
  output logic [4:0] o_pendientes,
  output logic [2:0] o_num_golpes,
  output logic [4:0] o_leds
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_CYCLES);
  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);

  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt     [5];
  logic [LED_W-1:0] r_led_cnt [5];
  logic [4:0]       r_estable;
  logic [4:0]       r_golpe;
  logic [4:0]       r_pend;
  logic [2:0]       r_num;

  logic [4:0]       w_differs;
  logic [4:0]       w_accept;
  logic [4:0]       w_golpe_next;
  logic [2:0]       w_num_next;

  // A bit is accepted on the edge where it has differed from the stable
  // level for DEBOUNCE_CYCLES consecutive samples. Only accepted rises
  // generate a pulse, and only while the game is enabled; a press accepted
  // while disabled is simply absorbed into o_estable, so it never pulses later.
  always_comb begin
    w_differs    = r_sync2 ^ r_estable;
    w_accept     = '0;
    w_num_next   = '0;
    for (int i = 0; i < 5; i++) begin
      w_accept[i] = w_differs[i] && (r_cnt[i] == DEB_LAST);
    end
    w_golpe_next = w_accept & r_sync2 & {5{i_enable}};
    for (int i = 0; i < 5; i++) begin
      w_num_next = w_num_next + 3'(w_golpe_next[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_botones;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: any sample that matches the stable level restarts the count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_estable <= '0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_differs[i]) begin
          if (w_accept[i]) begin
            r_estable[i] <= r_sync2[i];
            r_cnt[i]     <= '0;
          end else begin
            r_cnt[i]     <= r_cnt[i] + CNT_ONE;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // A pending flag is set the cycle after its pulse. Setting wins over
  // acknowledging, so a hit that lands while scoring is acking that pad
  // is not lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_golpe <= '0;
      r_num   <= '0;
      r_pend  <= '0;
    end else begin
      r_golpe <= w_golpe_next;
      r_num   <= w_num_next;
      r_pend  <= (r_pend & ~i_ack) | r_golpe;
    end
  end

  // The LED stretch reloads on every hit, so retriggers extend it, and it
  // stops decrementing once it reaches zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 5; i++) begin
        r_led_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_golpe[i]) begin
          r_led_cnt[i] <= LED_LOAD;
        end else if (r_led_cnt[i] != '0) begin
          r_led_cnt[i] <= r_led_cnt[i] - LED_ONE;
        end
      end
    end
  end

  always_comb begin
    o_leds = '0;
    for (int i = 0; i < 5; i++) begin
      o_leds[i] = (r_led_cnt[i] != '0);
    end
  end

  assign o_estable    = r_estable;
  assign o_golpe      = r_golpe;
  assign o_pendientes = r_pend;
  assign o_num_golpes = r_num;

endmodule

// File: tb/tb_acondicionador_botones.sv
// ---------------------------------------------------------------------------
// tb_acondicionador_botones
//   Directed bench for acondicionador_botones. It runs with DEBOUNCE_CYCLES=4
//   and LED_CYCLES=8. Expected output values are queued against absolute
//   clock-edge numbers when the stimulus is planned. They are popped and
//   compared 2 ns after that edge.
// ---------------------------------------------------------------------------
module tb_acondicionador_botones;

  localparam int S_EST = 0;
  localparam int S_GOL = 1;
  localparam int S_PEN = 2;
  localparam int S_NUM = 3;
  localparam int S_LED = 4;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic [4:0] i_botones;
  logic [4:0] i_ack;
  logic [4:0] o_estable;
  logic [4:0] o_golpe;
  logic [4:0] o_pendientes;
  logic [2:0] o_num_golpes;
  logic [4:0] o_leds;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .LED_CYCLES     (8),
    .LED_W          (4)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_botones    (i_botones),
    .i_ack        (i_ack),
    .o_estable    (o_estable),
    .o_golpe      (o_golpe),
    .o_pendientes (o_pendientes),
    .o_num_golpes (o_num_golpes),
    .o_leds       (o_leds)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [4:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input int c, input int s, input logic [4:0] v, input string t);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic pushr(input int c0, input int c1, input int s, input logic [4:0] v,
                       input string t);
    for (int c = c0; c <= c1; c++) push(c, s, v, t);
  endtask

  task automatic push_all_zero(input int c, input string t);
    for (int s = 0; s < 5; s++) push(c, s, 5'b0, t);
  endtask

  task automatic check_due();
    int         k;
    logic [4:0] obs;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc <= edge_n) begin
        case (sb[k].sel)
          S_EST:   obs = o_estable;
          S_GOL:   obs = o_golpe;
          S_PEN:   obs = o_pendientes;
          S_NUM:   obs = {2'b00, o_num_golpes};
          default: obs = o_leds;
        endcase
        n_cmp++;
        assert (obs === sb[k].val) else begin
          n_fail++;
          $error("FAIL %s sel=%0d edge %0d: observed %b expected %b",
                 sb[k].tag, sb[k].sel, edge_n, obs, sb[k].val);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    edge_n++;
    #2;
    check_due();
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  initial begin
    int b;
    int r;
    i_reset   = 1'b1;
    i_enable  = 1'b1;
    i_botones = '0;
    i_ack     = '0;

    // Reset state
    push_all_zero(2, "reset_state");
    tick_to(2);
    i_reset = 1'b0;

    // Clean press on bit4, held, then released and acknowledged
    b = edge_n;
    push(b+14, S_EST, 5'b00000, "t1_est_pre");
    push(b+14, S_GOL, 5'b00000, "t1_gol_pre");
    push(b+15, S_EST, 5'b10000, "t1_est");
    push(b+15, S_GOL, 5'b10000, "t1_gol");
    push(b+15, S_NUM, 5'd1,     "t1_num");
    push(b+15, S_PEN, 5'b00000, "t1_pen_pre");
    push(b+15, S_LED, 5'b00000, "t1_led_pre");
    push(b+16, S_NUM, 5'd0,     "t1_num_post");
    push(b+16, S_PEN, 5'b10000, "t1_pen");
    pushr(b+16, b+34, S_GOL, 5'b00000, "t1_no_repeat");
    pushr(b+16, b+23, S_LED, 5'b10000, "t1_led_on");
    push(b+24, S_LED, 5'b00000, "t1_led_off");
    push(b+34, S_EST, 5'b10000, "t1_est_held");
    push(b+35, S_EST, 5'b00000, "t1_est_rel");
    push(b+35, S_GOL, 5'b00000, "t1_no_rel_pulse");
    push(b+36, S_PEN, 5'b10000, "t1_pen_held");
    push(b+37, S_PEN, 5'b00000, "t1_pen_ack");
    tick_to(b+9);  i_botones = 5'b10000;
    tick_to(b+29); i_botones = 5'b00000;
    tick_to(b+36); i_ack = 5'b10000;
    tick_to(b+37); i_ack = 5'b00000;
    tick_to(b+40);

    // Bounce on bit2: 3 high, 1 low, 10 high, then release
    b = edge_n;
    pushr(b+12, b+18, S_GOL, 5'b00000, "t2_glitch_gol");
    pushr(b+12, b+18, S_EST, 5'b00000, "t2_glitch_est");
    push(b+19, S_GOL, 5'b00100, "t2_gol");
    push(b+19, S_EST, 5'b00100, "t2_est");
    push(b+19, S_NUM, 5'd1,     "t2_num");
    pushr(b+20, b+36, S_GOL, 5'b00000, "t2_single");
    push(b+20, S_PEN, 5'b00100, "t2_pen");
    push(b+27, S_LED, 5'b00100, "t2_led_last");
    push(b+28, S_LED, 5'b00000, "t2_led_off");
    push(b+28, S_EST, 5'b00100, "t2_est_held");
    push(b+29, S_EST, 5'b00000, "t2_est_rel");
    push(b+37, S_PEN, 5'b00000, "t2_pen_ack");
    tick_to(b+9);  i_botones = 5'b00100;
    tick_to(b+12); i_botones = 5'b00000;
    tick_to(b+13); i_botones = 5'b00100;
    tick_to(b+23); i_botones = 5'b00000;
    tick_to(b+36); i_ack = 5'b00100;
    tick_to(b+37); i_ack = 5'b00000;
    tick_to(b+40);

    // All five pads at once, partial ack, ack on already-clear bits
    b = edge_n;
    push(b+14, S_GOL, 5'b00000, "t3_gol_pre");
    push(b+15, S_GOL, 5'b11111, "t3_gol");
    push(b+15, S_NUM, 5'd5,     "t3_num");
    push(b+15, S_EST, 5'b11111, "t3_est");
    push(b+15, S_PEN, 5'b00000, "t3_pen_pre");
    push(b+16, S_GOL, 5'b00000, "t3_gol_post");
    push(b+16, S_NUM, 5'd0,     "t3_num_post");
    push(b+16, S_PEN, 5'b11111, "t3_pen");
    push(b+16, S_LED, 5'b11111, "t3_led");
    push(b+17, S_PEN, 5'b11010, "t3_pen_ack");
    push(b+18, S_PEN, 5'b11010, "t3_pen_keep");
    push(b+25, S_EST, 5'b00000, "t3_est_rel");
    push(b+25, S_GOL, 5'b00000, "t3_no_rel_pulse");
    push(b+26, S_PEN, 5'b00000, "t3_pen_clear");
    push(b+26, S_LED, 5'b00000, "t3_led_off");
    tick_to(b+9);  i_botones = 5'b11111;
    tick_to(b+16); i_ack = 5'b00101;
    tick_to(b+17); i_ack = 5'b00000;
    tick_to(b+19); i_botones = 5'b00000;
    tick_to(b+25); i_ack = 5'b11010;
    tick_to(b+26); i_ack = 5'b00000;
    tick_to(b+28);

    // Set/ack collision on pad 0 with ack held high throughout
    b = edge_n;
    push(b+15, S_GOL, 5'b00001, "t4_gol");
    push(b+15, S_PEN, 5'b00000, "t4_pen_pre");
    push(b+16, S_PEN, 5'b00001, "t4_pen_set_wins");
    push(b+16, S_LED, 5'b00001, "t4_led");
    push(b+17, S_PEN, 5'b00000, "t4_pen_acked");
    push(b+18, S_PEN, 5'b00000, "t4_pen_stays");
    push(b+25, S_EST, 5'b00000, "t4_est_rel");
    i_ack = 5'b00001;
    tick_to(b+9);  i_botones = 5'b00001;
    tick_to(b+19); i_botones = 5'b00000;
    tick_to(b+25); i_ack = 5'b00000;
    tick_to(b+26);

    // Press while disabled, then enable while still held
    b = edge_n;
    push(b+15, S_EST, 5'b00010, "t5_est");
    pushr(b+14, b+24, S_GOL, 5'b00000, "t5_no_gol");
    push(b+15, S_NUM, 5'd0, "t5_num");
    pushr(b+15, b+24, S_PEN, 5'b00000, "t5_no_pen");
    pushr(b+15, b+24, S_LED, 5'b00000, "t5_no_led");
    push(b+28, S_EST, 5'b00000, "t5_est_rel");
    push(b+28, S_GOL, 5'b00000, "t5_no_rel_pulse");
    i_enable = 1'b0;
    tick_to(b+9);  i_botones = 5'b00010;
    tick_to(b+17); i_enable = 1'b1;
    tick_to(b+22); i_botones = 5'b00000;
    tick_to(b+29);

    // Retrigger on pad 3, then async reset mid-stretch
    b = edge_n;
    push(b+15, S_GOL, 5'b01000, "t6_gol1");
    push(b+15, S_EST, 5'b01000, "t6_est1");
    pushr(b+16, b+22, S_GOL, 5'b00000, "t6_gap");
    push(b+16, S_PEN, 5'b01000, "t6_pen");
    push(b+19, S_EST, 5'b00000, "t6_est_rel");
    push(b+23, S_EST, 5'b01000, "t6_est2");
    push(b+23, S_GOL, 5'b01000, "t6_gol2");
    pushr(b+16, b+31, S_LED, 5'b01000, "t6_led_retrig");
    push(b+32, S_LED, 5'b00000, "t6_led_off");
    push(b+44, S_GOL, 5'b01000, "t6_gol3");
    push(b+45, S_LED, 5'b01000, "t6_led3");
    push(b+47, S_LED, 5'b01000, "t6_led_pre_rst");
    push(b+47, S_EST, 5'b01000, "t6_est_pre_rst");
    push(b+47, S_PEN, 5'b01000, "t6_pen_pre_rst");
    tick_to(b+9);  i_botones = 5'b01000;
    tick_to(b+13); i_botones = 5'b00000;
    tick_to(b+17); i_botones = 5'b01000;
    tick_to(b+32); i_botones = 5'b00000;
    tick_to(b+38); i_botones = 5'b01000;
    tick_to(b+47);
    i_reset = 1'b1;
    #1;
    push_all_zero(edge_n, "t6_async_rst");
    check_due();
    push_all_zero(edge_n + 1, "t6_rst_held");
    push_all_zero(edge_n + 2, "t6_rst_held");
    tick();
    tick();
    i_reset = 1'b0;

    // After release the held pad behaves as from power-up
    r = edge_n;
    push(r+5, S_EST, 5'b00000, "t6_pwrup_est_pre");
    push(r+5, S_GOL, 5'b00000, "t6_pwrup_gol_pre");
    push(r+6, S_EST, 5'b01000, "t6_pwrup_est");
    push(r+6, S_GOL, 5'b01000, "t6_pwrup_gol");
    push(r+6, S_NUM, 5'd1,     "t6_pwrup_num");
    push(r+7, S_PEN, 5'b01000, "t6_pwrup_pen");
    push(r+7, S_LED, 5'b01000, "t6_pwrup_led");
    tick_to(r+8);
    i_botones = 5'b00000;
    repeat (10) tick();

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
